// File: rtl/reset_modport_pkg.sv
// Shared types and default timing for the ULPI reset sequencer.
// The optional software re-sequence is enabled by defining RESET_SW_REQ_EN.
package reset_modport_pkg;

  typedef enum logic [2:0] {
    PHY_RST    = 3'd0,
    PHY_SETTLE = 3'd1,
    CORE_REL   = 3'd2,
    RUN        = 3'd3
  } rst_state_e;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_PHY_RST_CYCLES    = 16;
  localparam int DEF_PHY_SETTLE_CYCLES = 32;
  localparam int DEF_CNT_W             = 8;

  // Output bundle implied by a given state; shared so every output
  // flop is loaded from the same next-state decode.
  typedef struct packed {
    logic phy_reset;
    logic core_reset_n;
    logic done;
  } rst_outs_t;

  function automatic rst_outs_t outs_for_state(input rst_state_e st);
    rst_outs_t o;
    o.phy_reset    = (st == PHY_RST);
    o.core_reset_n = (st == CORE_REL) || (st == RUN);
    o.done         = (st == RUN);
    return o;
  endfunction

endpackage

// File: rtl/reset_modport_reset_sync.sv
// Asynchronous-assert / synchronous-deassert reset chain.
// rst_sync rises SYNC_STAGES rising edges after rst_n is released.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_modport.sv
// ULPI link reset sequencer: PHY reset pulse, settle window, core release.
// Define RESET_SW_REQ_EN to let sw_reset_req restart the sequence from RUN.
module reset_modport
  import reset_modport_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int PHY_RST_CYCLES    = DEF_PHY_RST_CYCLES,
  parameter int PHY_SETTLE_CYCLES = DEF_PHY_SETTLE_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic       phy_ulpi_clk,
  input  logic       reset_n,
  input  logic       sw_reset_req,
  output logic       phy_reset_o,
  output logic       core_reset_n_o,
  output logic       reset_done,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);

  logic       rst_sync;
  logic       soft_req;
  rst_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       phy_reset_q, phy_reset_d;
  logic       core_reset_n_q, core_reset_n_d;
  logic       reset_done_q, reset_done_d;
  rst_outs_t  outs_d;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk     (phy_ulpi_clk),
    .rst_n   (reset_n),
    .rst_sync(rst_sync)
  );

`ifdef RESET_SW_REQ_EN
  assign soft_req = sw_reset_req;
`else
  logic unused_sw_reset_req;
  assign unused_sw_reset_req = sw_reset_req;
  assign soft_req = 1'b0;
`endif

  // Counter is cleared on every state change and stops at its terminal
  // compare, so it never reaches 2^CNT_W.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_sync) begin
      case (state_q)
        PHY_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = PHY_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PHY_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = CORE_REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CORE_REL: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          if (soft_req) begin
            state_d = PHY_RST;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = PHY_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode next-state so they switch on the same edge as state.
  always_comb begin
    outs_d         = outs_for_state(state_d);
    phy_reset_d    = outs_d.phy_reset;
    core_reset_n_d = outs_d.core_reset_n;
    reset_done_d   = outs_d.done;
  end

  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= PHY_RST;
      cnt_q          <= '0;
      phy_reset_q    <= 1'b1;
      core_reset_n_q <= 1'b0;
      reset_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      phy_reset_q    <= phy_reset_d;
      core_reset_n_q <= core_reset_n_d;
      reset_done_q   <= reset_done_d;
    end
  end

  assign phy_reset_o    = phy_reset_q;
  assign core_reset_n_o = core_reset_n_q;
  assign reset_done     = reset_done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_reset_modport.sv
// Scoreboarded bench for reset_modport: default and corner-parameter instances.
// Vector layout: {state[2:0], phy_reset, core_reset_n, reset_done}.
module tb_reset_modport;

  logic       clk;
  logic       reset_n;
  logic       sw_reset_req;
  logic       sel_c;

  logic       phy_a, core_a, done_a;
  logic [2:0] state_a;
  logic       phy_c, core_c, done_c;
  logic [2:0] state_c;

  logic [5:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  localparam logic [5:0] RST_VEC = 6'b000_1_0_0;
  localparam logic [5:0] RUN_VEC = 6'b011_0_1_1;

  reset_modport dut (
    .phy_ulpi_clk  (clk),
    .reset_n       (reset_n),
    .sw_reset_req  (sw_reset_req),
    .phy_reset_o   (phy_a),
    .core_reset_n_o(core_a),
    .reset_done    (done_a),
    .state_o       (state_a)
  );

  reset_modport #(
    .SYNC_STAGES      (3),
    .PHY_RST_CYCLES   (1),
    .PHY_SETTLE_CYCLES(1)
  ) dut_c (
    .phy_ulpi_clk  (clk),
    .reset_n       (reset_n),
    .sw_reset_req  (sw_reset_req),
    .phy_reset_o   (phy_c),
    .core_reset_n_o(core_c),
    .reset_done    (done_c),
    .state_o       (state_c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] act_vec(input logic use_c);
    if (use_c) return {state_c, phy_c, core_c, done_c};
    return {state_a, phy_a, core_a, done_a};
  endfunction

  // Expected vector n edges into a sequence whose phy release, core release
  // and done edges are tp, tc, td.
  function automatic logic [5:0] tl(input int n, input int tp, input int tc, input int td);
    logic [2:0] st;
    logic       p, c, d;
    if (n < tp)      st = 3'd0;
    else if (n < tc) st = 3'd1;
    else if (n < td) st = 3'd2;
    else             st = 3'd3;
    p = (n < tp);
    c = (n >= tc);
    d = (n >= td);
    return {st, p, c, d};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_reset(input int cycles);
    for (int i = 0; i < cycles; i++) exp_q.push_back(RST_VEC);
  endtask

  task automatic push_seq(input int first, input int last, input int tp, input int tc, input int td);
    for (int n = first; n <= last; n++) exp_q.push_back(tl(n, tp, tc, td));
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: every rising edge, compare the selected DUT against the next expectation.
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(sel_c ? "corner_seq" : "main_seq", act_vec(sel_c), e);
    end
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    sw_reset_req = 1'b0;
    sel_c        = 1'b0;

    // Power-on: 5 cycles in reset, then the full default sequence.
    push_reset(5);
    wait_edges(5);
    @(negedge clk);
    reset_n = 1'b1;
    push_seq(1, 60, 18, 50, 51);
    wait_edges(60);
    @(negedge clk);

`ifdef RESET_SW_REQ_EN
    // Soft reset: one-cycle request sampled at edge E (k=0).
    sw_reset_req = 1'b1;
    push_seq(0, 54, 16, 48, 49);
    wait_edges(1);
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_edges(54);
    @(negedge clk);
`else
    // Request in RUN has no effect when the feature is compiled out.
    sw_reset_req = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(RUN_VEC);
    wait_edges(1);
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_edges(19);
    @(negedge clk);
`endif

    // Mid-sequence abort in PHY_SETTLE, asynchronously between edges.
    reset_n = 1'b0;
    push_reset(3);
    wait_edges(3);
    @(negedge clk);
    reset_n = 1'b1;
    push_seq(1, 30, 18, 50, 51);
    wait_edges(30);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_async", act_vec(1'b0), RST_VEC);
    @(negedge clk);
    push_reset(3);
    wait_edges(3);
    @(negedge clk);

    // Restart; request held through PHY_SETTLE must be ignored and not queued.
    reset_n = 1'b1;
    push_seq(1, 60, 18, 50, 51);
    wait_edges(20);
    @(negedge clk);
    sw_reset_req = 1'b1;
    wait_edges(25);
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_edges(15);
    @(negedge clk);

    // Corner instance: SYNC_STAGES=3, one-cycle reset and settle.
    reset_n = 1'b0;
    sel_c   = 1'b1;
    push_reset(3);
    wait_edges(3);
    @(negedge clk);
    reset_n = 1'b1;
    push_seq(1, 10, 4, 5, 6);
    wait_edges(10);
    #2;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
